// File: rtl/quant_post.sv
// Dequantizer: rebuilds an fp32 value from a 32-bit unsigned fixed-point activation
// aligned to Emax, using a multi-cycle leading-one normalizer behind valid/ready handshakes.
module quant_post #(
  parameter int STEP = 4  // bits skipped per NORM cycle when the top STEP bits are zero; 2, 4 or 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_max,
  input  logic        i_sign,
  input  logic [31:0] i_activation,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  localparam logic signed [9:0] STEP_S = 10'(STEP);

  state_t             state, state_nxt;
  logic [31:0]        r_data, data_nxt;
  logic signed [9:0]  r_exp, exp_nxt;
  logic               r_sign, sign_nxt;
  logic [31:0]        result_nxt;

  // Only the exponent field of the reference max carries information.
  logic unused_max;
  assign unused_max = ^{i_max[31], i_max[22:0]};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      r_data   <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      o_result <= '0;
    end else begin
      state    <= state_nxt;
      r_data   <= data_nxt;
      r_exp    <= exp_nxt;
      r_sign   <= sign_nxt;
      o_result <= result_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    data_nxt   = r_data;
    exp_nxt    = r_exp;
    sign_nxt   = r_sign;
    result_nxt = o_result;

    case (state)
      IDLE: begin
        if (i_valid) begin
          data_nxt = i_activation;
          sign_nxt = i_sign;
          exp_nxt  = {2'b00, i_max[30:23]};
          if (i_activation == 32'd0) begin
            result_nxt = {i_sign, 31'd0};
            state_nxt  = DONE;
          end else begin
            state_nxt  = NORM;
          end
        end
      end

      NORM: begin
        if (r_data[31]) begin
          state_nxt = DONE;
          if (r_exp <= 10'sd0)
            result_nxt = {r_sign, 31'd0};
          else if (r_exp >= 10'sd255)
            result_nxt = {r_sign, 8'hFE, 23'h7FFFFF};
          else
            result_nxt = {r_sign, r_exp[7:0], r_data[30:8]};
        end else if (r_data[31 -: STEP] == '0) begin
          data_nxt = r_data << STEP;
          exp_nxt  = r_exp - STEP_S;
        end else begin
          data_nxt = r_data << 1;
          exp_nxt  = r_exp - 10'sd1;
        end
      end

      DONE: begin
        if (i_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_quant_post.sv
// Self-checking bench for quant_post: directed cases plus randomized transfers
// compared against an arithmetic fp32 reconstruction model.
module tb_quant_post;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_max;
  logic        i_sign;
  logic [31:0] i_activation;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int checks = 0;
  int errors = 0;

  quant_post #(.STEP(STEP)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_max        (i_max),
    .i_sign       (i_sign),
    .i_activation (i_activation),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference model: value = act * 2^(Emax-127-31); normalize by the leading one.
  function automatic int count_lz(input logic [31:0] a);
    for (int i = 31; i >= 0; i--)
      if (a[i]) return 31 - i;
    return 32;
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] mx, input logic sg,
                                             input logic [31:0] act);
    int          lz;
    int          e;
    logic [31:0] nrm;
    if (act == 32'd0) return {sg, 31'd0};
    lz  = count_lz(act);
    e   = int'(mx[30:23]) - lz;
    nrm = act << lz;
    if (e <= 0)   return {sg, 31'd0};
    if (e >= 255) return {sg, 8'hFE, 23'h7FFFFF};
    return {sg, 8'(e), nrm[30:8]};
  endfunction

  // Edges from the accept edge (counted as 1) until o_valid is seen high.
  function automatic int ref_latency(input logic [31:0] act);
    int lz;
    if (act == 32'd0) return 1;
    lz = count_lz(act);
    return lz / STEP + lz % STEP + 2;
  endfunction

  task automatic transfer(input string tag, input logic [31:0] mx, input logic sg,
                          input logic [31:0] act, input int hold,
                          input logic [31:0] exp_res, input int exp_lat);
    int          edges;
    logic [31:0] held;
    @(negedge clk);
    check({tag, "_ready_idle"}, {31'd0, o_ready}, 32'd1);
    i_valid      = 1'b1;
    i_max        = mx;
    i_sign       = sg;
    i_activation = act;
    i_ready      = (hold == 0);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    i_valid      = 1'b0;
    i_max        = $urandom;
    i_sign       = 1'($urandom);
    i_activation = $urandom;
    while (!o_valid && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_ready_busy"}, {31'd0, o_ready}, 32'd0);
    held = o_result;
    for (int c = 0; c < hold; c++) begin
      i_valid = (c == 0);
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      check({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, "_hold_result"}, o_result, held);
      check({tag, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] mx, act;
    logic        sg;
    int          sh;

    reset        = 1'b1;
    i_valid      = 1'b0;
    i_max        = '0;
    i_sign       = 1'b0;
    i_activation = '0;
    i_ready      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    check("reset_ready", {31'd0, o_ready}, 32'd1);

    // Directed cases with hand-derived expectations.
    transfer("t1_one",   32'h3F800000, 1'b0, 32'h80000000, 0, 32'h3F800000, 2);
    transfer("t2_lz8",   32'h3F800000, 1'b0, 32'h00C00000, 0, 32'h3BC00000, 4);
    transfer("t3_zero",  32'h12345678, 1'b1, 32'h00000000, 0, 32'h80000000, 1);
    transfer("t4_uflow", 32'h01800000, 1'b0, 32'h00000001, 0, 32'h00000000, 12);
    transfer("t5_sat",   32'h7F800000, 1'b0, 32'hFF000000, 5, 32'h7F7FFFFF, 2);
    transfer("t5b_negsat", 32'hFF800000, 1'b1, 32'h80000001, 0, 32'hFF7FFFFF, 2);
    transfer("t_exp1",   32'h00800000, 1'b0, 32'h80000100, 0, 32'h00800001, 2);

    // Reset during the second NORM cycle aborts the transfer.
    @(negedge clk);
    i_valid      = 1'b1;
    i_max        = 32'h3F800000;
    i_sign       = 1'b0;
    i_activation = 32'h00000100;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    check("t6_rst_result", o_result, 32'd0);
    check("t6_rst_ready", {31'd0, o_ready}, 32'd1);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      check("t6_no_output", {31'd0, o_valid}, 32'd0);
    end
    transfer("t6_follow", 32'h3F800000, 1'b0, 32'h80000000, 0, 32'h3F800000, 2);

    // Randomized transfers against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      sh  = $urandom_range(0, 32);
      act = (sh == 32) ? 32'd0 : ($urandom | 32'h80000000) >> sh;
      if ($urandom_range(0, 3) == 0) act = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       mx = {1'($urandom), 8'($urandom_range(0, 8)), 23'($urandom)};
        1:       mx = {1'($urandom), 8'($urandom_range(247, 255)), 23'($urandom)};
        default: mx = $urandom;
      endcase
      sg = 1'($urandom);
      transfer($sformatf("rnd%0d", n), mx, sg, act, $urandom_range(0, 2),
               ref_result(mx, sg, act), ref_latency(act));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quant_post.md
Name: quant_post

Overview:
- Dequantizer: the inverse of the fp32-to-fixed pre-quantizer.
- Takes a 32-bit unsigned fixed-point activation aligned to the fp32 max's exponent and rebuilds an fp32 value.
- Sits at the output of the integer datapath, before results are written back as fp32.
- Multi-cycle leading-one normalizer behind a valid/ready handshake on both sides.

Parameters:
- STEP, 4: bits shifted per NORM cycle when the top STEP bits are all zero. Legal values are 2, 4, 8.

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  input transfer request
- o_ready  output  1  block can accept; high only in IDLE
- i_max  input  32  fp32 reference max; only [30:23] (Emax) is used
- i_sign  input  1  sign to restore on the output
- i_activation  input  32  unsigned fixed-point; bit 31 weighs 2^(Emax-127)
- o_valid  output  1  o_result valid
- i_ready  input  1  downstream accepts o_result
- o_result  output  32  reconstructed fp32

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - state=IDLE; o_valid=0; o_result=0; internal regs=0.
  - o_ready=1 from the following cycle.
  - Reset aborts any operation in flight; no output is produced for it.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - o_ready=1. Accept on an edge with i_valid&&o_ready.
  - On accept, latch r_data=i_activation, r_sign=i_sign, and r_exp as a 10-bit signed value {2'b0,Emax}.
  - If i_activation==0: o_result<={i_sign,31'b0}, go to DONE.
  - Otherwise go to NORM.
- NORM (one decision per cycle, priority order):
  - If r_data[31]==1: pack, go to DONE.
  - Else if r_data[31:32-STEP]==0: r_data<<=STEP, r_exp-=STEP.
  - Else: r_data<<=1, r_exp-=1.
- Pack rules:
  - r_exp<=0 (underflow): o_result={r_sign,31'b0}.
  - r_exp>=255 (only possible with Emax=255): o_result={r_sign,8'hFE,23'h7FFFFF} (saturate to max finite).
  - Otherwise: o_result={r_sign,r_exp[7:0],r_data[30:8]}. Mantissa is truncated, no rounding.
- DONE:
  - o_valid=1; o_ready=0; o_result held stable.
  - On an edge with i_ready=1: o_valid<=0, go to IDLE.
  - No accept is possible in the same cycle as the output handshake (o_ready=0 in DONE).
- Timing (lz = leading zeros of the activation):
  - NORM shift cycles n = floor(lz/STEP) + (lz mod STEP).
  - For nonzero input, o_valid rises n+2 edges after the accept edge.
  - For zero input, o_valid rises 1 edge after the accept edge.
- Inputs are sampled only on the accept edge. i_max, i_sign and i_activation may change afterwards without effect.
- i_valid while o_ready=0 is ignored; the block does not buffer it.
- Exponent arithmetic is signed 10-bit. It never wraps: at most 31 shifts, and Emax>=0.

Test Plan:
1. Emax=127 (i_max=0x3F800000), i_activation=0x80000000, i_sign=0, i_ready=1 -> o_result=0x3F800000; o_valid 2 edges after accept for 1 cycle; o_ready back high the next cycle.
2. Emax=127, i_activation=0x00C00000 (lz=8, STEP=4) -> 2 shift cycles; o_result=0x3BC00000; o_valid 4 edges after accept.
3. i_activation=0, i_sign=1, any i_max -> o_result=0x80000000; o_valid 1 edge after accept.
4. Emax=3, i_activation=0x00000001 (lz=31) -> 7+3=10 shift cycles, r_exp=-28 -> o_result=0x00000000 (underflow flush); o_valid 12 edges after accept.
5. Emax=255, i_activation=0xFF000000 -> o_result=0x7F7FFFFF. Also hold i_ready=0 for 5 cycles: o_valid and o_result stay stable, o_ready=0, and a pulsed i_valid is not accepted. Then i_ready=1 -> handshake completes; o_ready=1 the next cycle.
6. Emax=127, i_activation=0x00000100, assert reset during the 2nd NORM cycle -> next cycle o_valid=0, o_result=0, o_ready=1. A follow-up transfer of 0x80000000 yields 0x3F800000 with normal latency.
